// File: rtl/sdram_arbiter.sv
// sdram_arbiter: grants the SDRAM command bus to init, refresh, write or read sources
// Ports:
//   i_clk, i_rst                    clock, synchronous active-high reset
//   i_init_end/cmd/addr             init sequencer done flag, command, address
//   i_ref_rq/end/cmd/addr, o_ref_en refresh request, done, command, address, grant pulse
//   i_wr_rq/end/cmd/addr, o_wr_en   write request, done, command, address, grant pulse
//   o_wr_brk                        ask the writer to finish its burst (refresh pending)
//   i_rd_*, o_rd_en, o_rd_brk       read-side equivalents
//   o_sdram_cmd, o_sdram_addr       {cs_n, ras_n, cas_n, we_n} and address to the SDRAM
//   o_timeout_err                   one-cycle pulse when an operation overruns TIMEOUT
module sdram_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_init_end,
    input  logic [3:0]            i_init_cmd,
    input  logic [ADDR_WIDTH-1:0] i_init_addr,
    input  logic                  i_ref_rq,
    input  logic                  i_ref_end,
    input  logic [3:0]            i_ref_cmd,
    input  logic [ADDR_WIDTH-1:0] i_ref_addr,
    output logic                  o_ref_en,
    input  logic                  i_wr_rq,
    input  logic                  i_wr_end,
    input  logic [3:0]            i_wr_cmd,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    output logic                  o_wr_en,
    output logic                  o_wr_brk,
    input  logic                  i_rd_rq,
    input  logic                  i_rd_end,
    input  logic [3:0]            i_rd_cmd,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic                  o_rd_en,
    output logic                  o_rd_brk,
    output logic [3:0]            o_sdram_cmd,
    output logic [ADDR_WIDTH-1:0] o_sdram_addr,
    output logic                  o_timeout_err
);
    localparam logic [3:0] NOP = 4'b0111;
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT);
    localparam logic [WDW-1:0] WD_ONE  = WDW'(1);

    typedef enum logic [2:0] {INIT, ARBIT, AREF, WRITE, READ} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [WDW-1:0] r_wdog;
    logic           r_ref_en;
    logic           r_wr_en;
    logic           r_rd_en;
    logic           r_timeout_err;
    logic           r_last_wr;
    logic           r_ref_armed;
    logic           w_ref_gnt;
    logic           w_wr_gnt;
    logic           w_rd_gnt;
    logic           w_in_op;
    logic           w_op_end;
    logic           w_timeout;

    always_comb begin
        w_in_op   = (r_state == AREF) || (r_state == WRITE) || (r_state == READ);
        w_op_end  = (r_state == AREF)  ? i_ref_end :
                    (r_state == WRITE) ? i_wr_end  :
                    (r_state == READ)  ? i_rd_end  : 1'b0;
        // a finishing operation wins over a watchdog expiry on the same cycle
        w_timeout = w_in_op && !w_op_end && (r_wdog >= WD_LAST);
        // refresh only fires once per rising request (arming cleared on grant)
        w_ref_gnt = (r_state == ARBIT) && i_ref_rq && r_ref_armed;
        // round-robin: on contention, grant the side that did not go last
        w_wr_gnt  = (r_state == ARBIT) && !w_ref_gnt && i_wr_rq && (!i_rd_rq || !r_last_wr);
        w_rd_gnt  = (r_state == ARBIT) && !w_ref_gnt && i_rd_rq && (!i_wr_rq || r_last_wr);
        w_next    = r_state;
        case (r_state)
            INIT:    w_next = i_init_end ? ARBIT : INIT;
            ARBIT:   w_next = w_ref_gnt ? AREF : w_wr_gnt ? WRITE : w_rd_gnt ? READ : ARBIT;
            AREF,
            WRITE,
            READ:    w_next = (w_op_end || w_timeout) ? ARBIT : r_state;
            default: w_next = INIT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= INIT;
            r_ref_en      <= 1'b0;
            r_wr_en       <= 1'b0;
            r_rd_en       <= 1'b0;
            r_timeout_err <= 1'b0;
            r_wdog        <= '0;
            r_last_wr     <= 1'b0;
            r_ref_armed   <= 1'b1;
        end else begin
            r_state       <= w_next;
            r_ref_en      <= w_ref_gnt;
            r_wr_en       <= w_wr_gnt;
            r_rd_en       <= w_rd_gnt;
            r_timeout_err <= w_timeout;
            r_wdog        <= (w_ref_gnt || w_wr_gnt || w_rd_gnt) ? '0 :
                             (r_wdog != WD_MAX) ? r_wdog + WD_ONE : r_wdog;
            r_last_wr     <= w_wr_gnt ? 1'b1 : w_rd_gnt ? 1'b0 : r_last_wr;
            // re-arm whenever the request is seen low; an aborted refresh disarms
            r_ref_armed   <= (w_ref_gnt || (w_timeout && r_state == AREF)) ? 1'b0 :
                             !i_ref_rq ? 1'b1 : r_ref_armed;
        end
    end

    always_comb begin
        o_sdram_cmd  = NOP;
        o_sdram_addr = '0;
        if (!i_rst) begin
            case (r_state)
                INIT:    {o_sdram_cmd, o_sdram_addr} = {i_init_cmd, i_init_addr};
                AREF:    {o_sdram_cmd, o_sdram_addr} = {i_ref_cmd, i_ref_addr};
                WRITE:   {o_sdram_cmd, o_sdram_addr} = {i_wr_cmd, i_wr_addr};
                READ:    {o_sdram_cmd, o_sdram_addr} = {i_rd_cmd, i_rd_addr};
                default: {o_sdram_cmd, o_sdram_addr} = {NOP, {ADDR_WIDTH{1'b0}}};
            endcase
        end
    end

    assign o_ref_en      = r_ref_en && !i_rst;
    assign o_wr_en       = r_wr_en && !i_rst;
    assign o_rd_en       = r_rd_en && !i_rst;
    assign o_timeout_err = r_timeout_err && !i_rst;
    assign o_wr_brk      = !i_rst && (r_state == WRITE) && i_ref_rq;
    assign o_rd_brk      = !i_rst && (r_state == READ) && i_ref_rq;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: scoreboard bench for sdram_arbiter
module tb_sdram_arbiter;
    localparam int AW = 12;
    localparam int TO = 15;
    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] INIT_CMD = 4'b0010;
    localparam logic [3:0] REF_CMD = 4'b0001;
    localparam logic [3:0] WR_CMD = 4'b0100;
    localparam logic [3:0] RD_CMD = 4'b0101;
    localparam logic [1:0] G_REF = 2'd1;
    localparam logic [1:0] G_WR = 2'd2;
    localparam logic [1:0] G_RD = 2'd3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_end = 1'b0;
    logic [3:0]    init_cmd = INIT_CMD;
    logic [AW-1:0] init_addr = 12'h011;
    logic          ref_rq = 1'b0, ref_end = 1'b0;
    logic [3:0]    ref_cmd = REF_CMD;
    logic [AW-1:0] ref_addr = 12'h400;
    logic          wr_rq = 1'b0, wr_end = 1'b0;
    logic [3:0]    wr_cmd = WR_CMD;
    logic [AW-1:0] wr_addr = 12'h123;
    logic          rd_rq = 1'b0, rd_end = 1'b0;
    logic [3:0]    rd_cmd = RD_CMD;
    logic [AW-1:0] rd_addr = 12'h456;
    logic          ref_en, wr_en, wr_brk, rd_en, rd_brk, timeout_err;
    logic [3:0]    sdram_cmd;
    logic [AW-1:0] sdram_addr;

    int n_chk = 0;
    int n_fail = 0;
    logic [1:0] exp_q[$];

    sdram_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_init_end(init_end), .i_init_cmd(init_cmd), .i_init_addr(init_addr),
        .i_ref_rq(ref_rq), .i_ref_end(ref_end), .i_ref_cmd(ref_cmd), .i_ref_addr(ref_addr),
        .o_ref_en(ref_en),
        .i_wr_rq(wr_rq), .i_wr_end(wr_end), .i_wr_cmd(wr_cmd), .i_wr_addr(wr_addr),
        .o_wr_en(wr_en), .o_wr_brk(wr_brk),
        .i_rd_rq(rd_rq), .i_rd_end(rd_end), .i_rd_cmd(rd_cmd), .i_rd_addr(rd_addr),
        .o_rd_en(rd_en), .o_rd_brk(rd_brk),
        .o_sdram_cmd(sdram_cmd), .o_sdram_addr(sdram_addr), .o_timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // every grant pulse is matched against the next expected grant
    always @(negedge clk) begin
        if (ref_en || wr_en || rd_en) begin
            logic [1:0] g;
            g = ref_en ? G_REF : wr_en ? G_WR : G_RD;
            check("grant_onehot", $countones({ref_en, wr_en, rd_en}), 1);
            if (exp_q.size() == 0) check("grant_unexpected", {30'b0, g}, 0);
            else check("grant_order", {30'b0, g}, {30'b0, exp_q.pop_front()});
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_grant();
        for (int k = 0; k < 10 && !(ref_en || wr_en || rd_en); k++) tick();
        check("grant_wait", ref_en || wr_en || rd_en, 1);
    endtask

    task automatic do_init();
        init_end = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("init_cmd", sdram_cmd, INIT_CMD);
            tick();
        end
        init_end = 1'b1;
        check("init_last_cmd", sdram_cmd, INIT_CMD);
        check("init_addr", sdram_addr, 12'h011);
        tick();
        check("arbit_cmd", sdram_cmd, NOP);
        check("arbit_addr", sdram_addr, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        tick(2);
        check("rst_cmd", sdram_cmd, NOP);
        check("rst_addr", sdram_addr, 0);
        check("rst_outs", {ref_en, wr_en, rd_en, wr_brk, rd_brk, timeout_err}, 0);
        rst = 1'b0;
        #1;
        do_init();
        // contention after reset: write first, then alternate
        wr_rq = 1'b1;
        rd_rq = 1'b1;
        exp_q.push_back(G_WR); exp_q.push_back(G_RD);
        exp_q.push_back(G_WR); exp_q.push_back(G_RD);
        for (int i = 0; i < 4; i++) begin
            wait_grant();
            if (i == 3) begin
                wr_rq = 1'b0;
                rd_rq = 1'b0;
            end
            check("rr_cmd", sdram_cmd, (i % 2 == 0) ? WR_CMD : RD_CMD);
            tick(7);
            if (i % 2 == 0) wr_end = 1'b1; else rd_end = 1'b1;
            tick();
            wr_end = 1'b0;
            rd_end = 1'b0;
            check("rr_gap_cmd", sdram_cmd, NOP);
        end
        // refresh beats a simultaneous write
        ref_rq = 1'b1;
        wr_rq = 1'b1;
        exp_q.push_back(G_REF); exp_q.push_back(G_WR);
        wait_grant();
        check("ref_cmd", sdram_cmd, REF_CMD);
        check("ref_addr", sdram_addr, 12'h400);
        check("ref_no_wr", wr_en, 0);
        tick(2);
        ref_end = 1'b1;
        tick();
        ref_end = 1'b0;
        check("ref_gap_cmd", sdram_cmd, NOP);
        check("ref_gap_en", {ref_en, wr_en, rd_en}, 0);
        wait_grant();
        check("wr_after_ref_cmd", sdram_cmd, WR_CMD);
        check("wr_brk_held_ref", wr_brk, 1);
        ref_rq = 1'b0;
        wr_rq = 1'b0;
        #1;
        check("wr_brk_drop", wr_brk, 0);
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        check("wr_done_cmd", sdram_cmd, NOP);
        // refresh arrives during a write: break, then refresh
        wr_rq = 1'b1;
        exp_q.push_back(G_WR);
        wait_grant();
        wr_rq = 1'b0;
        check("brk_idle", wr_brk, 0);
        tick(3);
        ref_rq = 1'b1;
        exp_q.push_back(G_REF);
        #1;
        check("brk_rise", wr_brk, 1);
        check("brk_rd_idle", rd_brk, 0);
        tick(2);
        check("brk_hold", wr_brk, 1);
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        check("brk_after", wr_brk, 0);
        check("brk_gap_cmd", sdram_cmd, NOP);
        wait_grant();
        check("brk_ref_cmd", sdram_cmd, REF_CMD);
        ref_end = 1'b1;
        ref_rq = 1'b0;
        tick();
        ref_end = 1'b0;
        // read that never ends trips the watchdog; foreign x_end ignored
        rd_rq = 1'b1;
        exp_q.push_back(G_RD);
        wait_grant();
        rd_rq = 1'b0;
        for (int k = 1; k <= TO - 1; k++) begin
            wr_end = (k == 5);
            ref_end = (k == 5);
            tick();
            check("wd_quiet", timeout_err, 0);
            if (k == TO - 1) check("wd_rd_cmd", sdram_cmd, RD_CMD);
        end
        tick();
        check("wd_pulse", timeout_err, 1);
        check("wd_arbit_cmd", sdram_cmd, NOP);
        tick();
        check("wd_pulse_end", timeout_err, 0);
        // reset in the middle of a refresh
        ref_rq = 1'b1;
        exp_q.push_back(G_REF);
        wait_grant();
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_cmd", sdram_cmd, NOP);
        check("mid_rst_outs", {ref_en, wr_en, rd_en, wr_brk, rd_brk, timeout_err}, 0);
        ref_end = 1'b1;
        tick();
        rst = 1'b0;
        ref_end = 1'b0;
        ref_rq = 1'b0;
        init_end = 1'b0;
        #1;
        check("post_rst_init", sdram_cmd, INIT_CMD);
        check("post_rst_outs", {ref_en, wr_en, rd_en, timeout_err}, 0);
        do_init();
        // init_end dropping after init is ignored
        init_end = 1'b0;
        tick(3);
        check("init_end_ignored", sdram_cmd, NOP);
        // reset restores write-first round robin
        wr_rq = 1'b1;
        rd_rq = 1'b1;
        exp_q.push_back(G_WR);
        wait_grant();
        wr_rq = 1'b0;
        rd_rq = 1'b0;
        check("rr_reset_cmd", sdram_cmd, WR_CMD);
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        tick(2);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, sets the SDRAM address bus width.
REQ-002 Parameter TIMEOUT, default 1023, is the maximum number of cycles allowed in one granted operation.
REQ-003 clk  in  1  100 MHz system clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 init_end  in  1  level; power-up initialisation complete.
REQ-006 init_cmd / init_addr  in  4 / ADDR_WIDTH  command and address from the init sequencer.
REQ-007 ref_rq  in  1  refresh request level from the refresh generator.
REQ-008 ref_end  in  1  refresh sequence done.
REQ-009 ref_cmd / ref_addr  in  4 / ADDR_WIDTH  refresh command and address.
REQ-010 ref_en  out  1  refresh grant, one-cycle pulse.
REQ-011 wr_rq, wr_end  in  1  write request level and write-burst done.
REQ-012 wr_cmd / wr_addr  in  4 / ADDR_WIDTH  write command and address.
REQ-013 wr_en, wr_brk  out  1  write grant pulse, and break request (finish current burst, then end).
REQ-014 rd_rq, rd_end, rd_cmd, rd_addr, rd_en, rd_brk  read-side equivalents of REQ-011..REQ-013, same directions and widths.
REQ-015 sdram_cmd  out  4  {cs_n, ras_n, cas_n, we_n} to the SDRAM.
REQ-016 sdram_addr  out  ADDR_WIDTH  address to the SDRAM.
REQ-017 timeout_err  out  1  one-cycle pulse on watchdog expiry.

Function
REQ-018 State register SHALL hold exactly these states: INIT, ARBIT, AREF, WRITE, READ.
REQ-019 Commands: NOP = 0111, A_REF = 0001, PRECHARGE = 0010, MRS = 0000.
REQ-020 INIT: sdram_cmd/sdram_addr = init_cmd/init_addr; go to ARBIT on the cycle after init_end is sampled 1.
REQ-021 ARBIT: sdram_cmd = NOP, sdram_addr = 0; evaluate requests each cycle.
REQ-022 Priority in ARBIT: ref_rq, then wr_rq/rd_rq.
REQ-023 If wr_rq and rd_rq are both high with no ref_rq, grant the one not granted last (round-robin); after reset the last grant is read, so write goes first.
REQ-024 Grant: the chosen x_en is registered high for exactly one cycle, coincident with the first cycle in AREF/WRITE/READ.
REQ-025 AREF/WRITE/READ: sdram_cmd/sdram_addr SHALL combinationally follow the granted source's cmd/addr (zero added latency).
REQ-026 AREF/WRITE/READ return to ARBIT the cycle after the matching x_end is sampled 1; other x_end inputs are ignored.
REQ-027 At least one ARBIT cycle (NOP) separates consecutive operations.
REQ-028 wr_brk = 1 while state is WRITE and ref_rq = 1; rd_brk likewise in READ; both are 0 in all other states.
REQ-029 Requests arriving outside ARBIT are not latched; the requester holds x_rq until granted.
REQ-030 ref_rq still high on return from AREF SHALL NOT be regranted unless it fell and rose again since the last ref_en (edge-armed refresh).
REQ-031 Watchdog: a counter clears on entry to AREF/WRITE/READ and increments each cycle.
REQ-032 At TIMEOUT without x_end: go to ARBIT, pulse timeout_err for one cycle, clear the refresh arming only if the state was AREF.
REQ-033 The watchdog counter saturates and never wraps.
REQ-034 init_end falling to 0 outside INIT is ignored.

Reset
REQ-035 While rst = 1: state = INIT; sdram_cmd = NOP forced (not init_cmd); sdram_addr = 0.
REQ-036 While rst = 1: ref_en, wr_en, rd_en, wr_brk, rd_brk, timeout_err = 0; watchdog = 0; last-grant = read; refresh arming = armed.
REQ-037 Reset mid-operation SHALL abandon the operation immediately, with no x_en or x_end handshake completed.

Verification
REQ-038 init_cmd = 0010 for 3 cycles, then init_end = 1 -> sdram_cmd = 0010 during INIT, then 0111 in ARBIT the next cycle.
REQ-039 ref_rq and wr_rq rise in the same ARBIT cycle -> ref_en pulses once, wr_en = 0; sdram_cmd follows ref_cmd (0001 seen); after ref_end, one NOP, then wr_en pulses.
REQ-040 wr_rq and rd_rq held high together with repeated x_end after 8 cycles -> grant order is W, R, W, R.
REQ-041 ref_rq rises at cycle 3 of WRITE -> wr_brk = 1 from that cycle until wr_end; next grant is ref_en.
REQ-042 Grant READ, never assert rd_end, TIMEOUT = 15 -> timeout_err pulses 15 cycles after entry, then state = ARBIT.
REQ-043 rst = 1 for one cycle in the middle of AREF -> next cycle sdram_cmd = 0111, all enables 0, state = INIT.
